// File: rtl/aes_link_pkg.sv
// Shared definitions for the AES UART frame link.
//   CMD_*    : command bytes accepted after the SYNC0/SYNC1 header
//   ACK/NAK  : default status bytes
//   link_state_t : main FSM state, also exported on the debug 'state' port
//   tx_req_t : request from the frame FSM to the TX serializer
package aes_link_pkg;

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] CMD_DEC = 8'h44;
    localparam logic [7:0] ACK_DEF = 8'h06;
    localparam logic [7:0] NAK_DEF = 8'h15;

    typedef enum logic [3:0] {
        ST_HUNT     = 4'd0,
        ST_SYNC     = 4'd1,
        ST_CMD      = 4'd2,
        ST_PAYLOAD  = 4'd3,
        ST_KEYWAIT  = 4'd4,
        ST_COREWAIT = 4'd5,
        ST_SEND     = 4'd6
    } link_state_t;

    // go: 1-cycle start; with_res: append the result block after the status byte
    typedef struct packed {
        logic       go;
        logic [7:0] status;
        logic       with_res;
    } tx_req_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_KEY) || (b == CMD_ENC) || (b == CMD_DEC);
    endfunction

endpackage

// File: rtl/aes_link_tx_ser.sv
// Reply serializer: latches a status byte (and optionally a result block) on
// req.go, then plays the bytes out one at a time over the UART handshake.
//   sys_clk, rst_n : clock, async active-low reset
//   req            : start pulse, status byte, result-present flag
//   res            : result block, sampled on req.go when with_res is set
//   tx_done        : UART finished the current byte
//   tx_start       : 1-cycle send strobe, one cycle after req.go / tx_done
//   tx_data        : byte at the current index (0 = status, then MSB first)
//   done           : 1-cycle pulse after the last byte's tx_done
module aes_link_tx_ser
    import aes_link_pkg::*;
#(
    parameter int BLOCK_BYTES = 16
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  tx_req_t                  req,
    input  logic [8*BLOCK_BYTES-1:0] res,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic                     done
);

    localparam int IW = $clog2(BLOCK_BYTES + 1);
    localparam logic [IW-1:0] RES_LAST = IW'(BLOCK_BYTES);

    logic                     busy;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            last;
    logic [7:0]               status;
    logic [8*BLOCK_BYTES-1:0] rbuf;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            idx      <= '0;
            last     <= '0;
            status   <= '0;
            rbuf     <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (req.go) begin
                busy     <= 1'b1;
                idx      <= '0;
                status   <= req.status;
                last     <= req.with_res ? RES_LAST : '0;
                if (req.with_res) rbuf <= res;
                tx_start <= 1'b1;
            end else if (busy && tx_done) begin
                if (idx == last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    // index moves together with the next tx_start, so tx_data
                    // holds steady for the whole byte
                    idx      <= idx + IW'(1);
                    tx_start <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        tx_data = status;
        for (int i = 0; i < BLOCK_BYTES; i++)
            if (idx == IW'(i + 1)) tx_data = rbuf[8*(BLOCK_BYTES-1-i) +: 8];
    end

endmodule

// File: rtl/aes_uart_frame_link.sv
// UART byte-stream front end for the AES core.
// Parses SYNC0 SYNC1 CMD PAYLOAD[BLOCK_BYTES], issues key load / encrypt /
// decrypt to the core and replies with ACK/NAK plus the result block.
//   sys_clk, rst_n         : clock, async active-low reset
//   rx_valid, rx_data      : received byte strobe and data
//   tx_start, tx_data      : reply byte strobe and data; tx_done from the UART
//   core_kld, core_ld      : 1-cycle key / data load strobes
//   core_dec               : 1 = decrypt, valid with core_ld
//   core_key, core_text_in : payload block, byte 0 in the MSBs
//   core_kdone, core_done  : core completion strobes; core_text_out = result
//   key_valid              : a key has been loaded since reset
//   frame_err              : pulse on timeout, bad command, data before key
//   drop_cnt               : saturating count of bytes ignored while busy
//   state                  : FSM state for debug
module aes_uart_frame_link
    import aes_link_pkg::*;
#(
    parameter int         BLOCK_BYTES = 16,
    parameter logic [7:0] SYNC0       = 8'hA5,
    parameter logic [7:0] SYNC1       = 8'h5A,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] ACK         = ACK_DEF,
    parameter logic [7:0] NAK         = NAK_DEF
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic                     core_kld,
    output logic                     core_ld,
    output logic                     core_dec,
    output logic [8*BLOCK_BYTES-1:0] core_key,
    output logic [8*BLOCK_BYTES-1:0] core_text_in,
    input  logic                     core_kdone,
    input  logic                     core_done,
    input  logic [8*BLOCK_BYTES-1:0] core_text_out,
    output logic                     key_valid,
    output logic                     frame_err,
    output logic [7:0]               drop_cnt,
    output logic [3:0]               state
);

    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BLOCK_BYTES - 1);
    localparam logic [23:0]   TO_LAST   = 24'(TIMEOUT_CYC - 1);

    link_state_t st_q, st_d;
    logic [CW-1:0] bcnt;
    logic [7:0]    cmd;
    logic [BW-1:0] blk;
    logic [23:0]   tcnt;
    logic          kld_d, ld_d, err_d;
    logic          in_frame, busy_st, to_hit;
    logic          ser_done;
    tx_req_t       req;

    assign in_frame = st_q inside {ST_SYNC, ST_CMD, ST_PAYLOAD};
    assign busy_st  = st_q inside {ST_KEYWAIT, ST_COREWAIT, ST_SEND};
    // a byte arriving on the terminal count wins over the timeout
    assign to_hit   = in_frame && !rx_valid && (tcnt == TO_LAST);

    always_comb begin
        st_d  = st_q;
        kld_d = 1'b0;
        ld_d  = 1'b0;
        err_d = 1'b0;
        req   = '0;
        if (to_hit) begin
            err_d = 1'b1;
            st_d  = ST_HUNT;
        end else begin
            case (st_q)
                ST_HUNT:
                    if (rx_valid && rx_data == SYNC0) st_d = ST_SYNC;
                ST_SYNC:
                    if (rx_valid) begin
                        if (rx_data == SYNC1)      st_d = ST_CMD;
                        else if (rx_data != SYNC0) st_d = ST_HUNT;
                    end
                ST_CMD:
                    if (rx_valid) begin
                        if (is_cmd(rx_data)) begin
                            st_d = ST_PAYLOAD;
                        end else begin
                            err_d      = 1'b1;
                            req.go     = 1'b1;
                            req.status = NAK;
                            st_d       = ST_SEND;
                        end
                    end
                ST_PAYLOAD:
                    if (rx_valid && bcnt == LAST_BYTE) begin
                        if (cmd == CMD_KEY) begin
                            kld_d = 1'b1;
                            st_d  = ST_KEYWAIT;
                        end else if (key_valid) begin
                            ld_d = 1'b1;
                            st_d = ST_COREWAIT;
                        end else begin
                            err_d      = 1'b1;
                            req.go     = 1'b1;
                            req.status = NAK;
                            st_d       = ST_SEND;
                        end
                    end
                ST_KEYWAIT:
                    if (core_kdone) begin
                        req.go     = 1'b1;
                        req.status = ACK;
                        st_d       = ST_SEND;
                    end
                ST_COREWAIT:
                    // the serializer samples core_text_out in this same cycle
                    if (core_done) begin
                        req.go       = 1'b1;
                        req.status   = ACK;
                        req.with_res = 1'b1;
                        st_d         = ST_SEND;
                    end
                ST_SEND:
                    if (ser_done) st_d = ST_HUNT;
                default:
                    st_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_HUNT;
            bcnt      <= '0;
            cmd       <= '0;
            blk       <= '0;
            tcnt      <= '0;
            key_valid <= 1'b0;
            drop_cnt  <= '0;
            core_kld  <= 1'b0;
            core_ld   <= 1'b0;
            core_dec  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            st_q      <= st_d;
            core_kld  <= kld_d;
            core_ld   <= ld_d;
            frame_err <= err_d;
            tcnt      <= (in_frame && !rx_valid && !to_hit) ? tcnt + 24'd1 : '0;
            if (st_q == ST_CMD && rx_valid) begin
                cmd  <= rx_data;
                bcnt <= '0;
            end
            // blk only shifts in PAYLOAD, so it stays frozen while the core
            // and the reply are in flight
            if (st_q == ST_PAYLOAD && rx_valid) begin
                blk  <= BW'({blk, rx_data});
                bcnt <= bcnt + CW'(1);
            end
            if (ld_d) core_dec <= (cmd == CMD_DEC);
            if (kld_d)
                key_valid <= 1'b0;
            else if (st_q == ST_KEYWAIT && core_kdone)
                key_valid <= 1'b1;
            if (busy_st && rx_valid && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign state        = st_q;
    assign core_key     = blk;
    assign core_text_in = blk;

    aes_link_tx_ser #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_tx_ser (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .req      (req),
        .res      (core_text_out),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_aes_uart_frame_link.sv
// Bench for aes_uart_frame_link: UART and AES-core stand-ins, frame-level
// reference model, directed vectors plus randomized frames.
module tb_aes_uart_frame_link;
    import aes_link_pkg::*;

    localparam int BB = 16;
    localparam int BW = 128;
    localparam int TO = 300;

    localparam logic [BW-1:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [BW-1:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BW-1:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done = 1'b0;
    logic          core_kld, core_ld, core_dec;
    logic [BW-1:0] core_key, core_text_in;
    logic          core_kdone = 1'b0, core_done = 1'b0;
    logic [BW-1:0] core_text_out = '0;
    logic          key_valid, frame_err;
    logic [7:0]    drop_cnt;
    logic [3:0]    state;

    aes_uart_frame_link #(
        .BLOCK_BYTES (BB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_done       (tx_done),
        .core_kld      (core_kld),
        .core_ld       (core_ld),
        .core_dec      (core_dec),
        .core_key      (core_key),
        .core_text_in  (core_text_in),
        .core_kdone    (core_kdone),
        .core_done     (core_done),
        .core_text_out (core_text_out),
        .key_valid     (key_valid),
        .frame_err     (frame_err),
        .drop_cnt      (drop_cnt),
        .state         (state)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stand-in core: the two published vectors, otherwise a keyed XOR
    // (self-inverse, so encrypt-then-decrypt round-trips)
    function automatic logic [BW-1:0] core_fn(input logic [BW-1:0] t, input logic [BW-1:0] k, input logic d);
        if (k == KEY1 && !d && t == PT1) return CT1;
        if (k == KEY1 &&  d && t == CT1) return PT1;
        return t ^ {k[63:0], k[127:64]};
    endfunction

    // UART stand-in: collects sent bytes, answers each with tx_done after 3..6 cycles
    logic [7:0] got_q[$];
    int u_wait = 0;
    int cyc = 0;
    int last_done = -10;
    initial forever begin
        @(negedge sys_clk);
        cyc++;
        if (!rst_n) begin
            u_wait  = 0;
            tx_done = 1'b0;
        end else begin
            if (tx_start) begin
                if (u_wait != 0) chk("tx_start_while_busy", 1, 0);
                if (got_q.size() > 0) chk("tx_gap", cyc - last_done, 1);
                got_q.push_back(tx_data);
                u_wait = $urandom_range(3, 6);
            end
            tx_done = 1'b0;
            if (u_wait > 0) begin
                u_wait--;
                if (u_wait == 0) begin
                    chk("tx_data_stable", tx_data, got_q[$]);
                    tx_done   = 1'b1;
                    last_done = cyc;
                end
            end
        end
    end

    // AES core stand-in plus strobe counters
    int n_err = 0, n_kld = 0, n_ld = 0;
    int kd_wait = 0, cd_wait = 0, kdone_delay = 10;
    logic          last_dec = 1'b0;
    logic [BW-1:0] m_core_key = '0, cd_res = '0;
    initial forever begin
        @(negedge sys_clk);
        core_kdone    = 1'b0;
        core_done     = 1'b0;
        core_text_out = {$urandom, $urandom, $urandom, $urandom};
        if (!rst_n) begin
            kd_wait = 0;
            cd_wait = 0;
        end else begin
            if (kd_wait > 0) begin
                kd_wait--;
                if (kd_wait == 0) core_kdone = 1'b1;
            end
            if (cd_wait > 0) begin
                cd_wait--;
                if (cd_wait == 0) begin
                    core_done     = 1'b1;
                    core_text_out = cd_res;
                end
            end
            if (frame_err) n_err++;
            if (core_kld && core_ld) chk("kld_ld_exclusive", 1, 0);
            if (core_kld) begin
                n_kld++;
                m_core_key = core_key;
                kd_wait    = kdone_delay;
            end
            if (core_ld) begin
                n_ld++;
                last_dec = core_dec;
                cd_res   = core_fn(core_text_in, m_core_key, core_dec);
                cd_wait  = $urandom_range(3, 12);
            end
        end
    end

    // reference state, frame level
    logic          m_kv = 1'b0;
    logic [BW-1:0] m_key = '0;
    int            m_drop = 0;
    logic [BW-1:0] last_res;
    logic [7:0]    bq[$];

    // drive bq; biggap = byte index followed by TO-1 idle cycles; ndrop bytes
    // follow the last byte back-to-back while the link is busy
    task automatic drive(input int biggap, input int ndrop);
        int g;
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge sys_clk);
            rx_valid = 1'b1;
            rx_data  = bq[i];
            if (i != bq.size() - 1) begin
                g = (i == biggap) ? TO - 1 : $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge sys_clk);
                    rx_valid = 1'b0;
                end
            end
        end
        repeat (ndrop) begin
            @(negedge sys_clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_reply(input int nexp, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4000 && !ok; c++) begin
            @(negedge sys_clk);
            if (got_q.size() >= nexp && state == ST_HUNT && u_wait == 0 && !tx_start) ok = 1'b1;
        end
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cb, input logic [BW-1:0] pl,
                             input int njunk, input bit dup, input int ndrop, input int biggap);
        logic [7:0]    exp_q[$];
        logic [7:0]    j;
        logic [BW-1:0] r;
        int            e0, k0, l0, exp_err, exp_kld, exp_ld;
        bit            ok, vcmd;
        vcmd = (cb == CMD_KEY) || (cb == CMD_ENC) || (cb == CMD_DEC);
        bq = {};
        repeat (njunk) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h00;
            bq.push_back(j);
        end
        if (dup) bq.push_back(8'hA5);
        bq.push_back(8'hA5);
        bq.push_back(8'h5A);
        bq.push_back(cb);
        if (vcmd) for (int i = 0; i < BB; i++) bq.push_back(pl[BW-1-8*i -: 8]);
        exp_err = 0; exp_kld = 0; exp_ld = 0;
        if (!vcmd) begin
            exp_q.push_back(NAK_DEF); exp_err = 1;
        end else if (cb == CMD_KEY) begin
            exp_q.push_back(ACK_DEF); exp_kld = 1;
        end else if (!m_kv) begin
            exp_q.push_back(NAK_DEF); exp_err = 1;
        end else begin
            r = core_fn(pl, m_key, cb == CMD_DEC);
            exp_q.push_back(ACK_DEF);
            for (int i = 0; i < BB; i++) exp_q.push_back(r[BW-1-8*i -: 8]);
            exp_ld = 1;
        end
        m_drop = (m_drop + ndrop > 255) ? 255 : m_drop + ndrop;
        got_q = {};
        e0 = n_err; k0 = n_kld; l0 = n_ld;
        drive(biggap, ndrop);
        if (cb == CMD_KEY && kdone_delay > ndrop + 10) begin
            chk({tag, ":kv_low_in_keywait"}, key_valid, 0);
            chk({tag, ":state_keywait"}, state, ST_KEYWAIT);
        end
        wait_reply(exp_q.size(), ok);
        chk({tag, ":reply_done"}, ok, 1);
        chk({tag, ":reply_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s:byte%0d", tag, i), (i < got_q.size()) ? {120'd0, got_q[i]} : 128'h100, exp_q[i]);
        chk({tag, ":frame_err"}, n_err - e0, exp_err);
        chk({tag, ":kld_cnt"}, n_kld - k0, exp_kld);
        chk({tag, ":ld_cnt"}, n_ld - l0, exp_ld);
        if (exp_ld == 1) chk({tag, ":core_dec"}, last_dec, cb == CMD_DEC);
        if (cb == CMD_KEY) begin
            m_kv  = 1'b1;
            m_key = pl;
        end
        chk({tag, ":key_valid"}, key_valid, m_kv);
        chk({tag, ":drop_cnt"}, drop_cnt, m_drop);
        last_res = '0;
        for (int i = 1; i < got_q.size() && i <= BB; i++) last_res = {last_res[BW-9:0], got_q[i]};
    endtask

    initial begin
        int e0;
        bit ok;
        logic [7:0] cb;
        logic [BW-1:0] pl;

        repeat (3) @(negedge sys_clk);
        chk("rst:tx_start", tx_start, 0);
        chk("rst:tx_data", tx_data, 0);
        chk("rst:core_kld", core_kld, 0);
        chk("rst:core_ld", core_ld, 0);
        chk("rst:core_dec", core_dec, 0);
        chk("rst:core_key", core_key, 0);
        chk("rst:core_text_in", core_text_in, 0);
        chk("rst:key_valid", key_valid, 0);
        chk("rst:frame_err", frame_err, 0);
        chk("rst:drop_cnt", drop_cnt, 0);
        chk("rst:state", state, ST_HUNT);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // data before key, bad command
        run_frame("enc_nokey", CMD_ENC, PT1, 0, 0, 0, -1);
        run_frame("bad_cmd", 8'h58, '0, 0, 0, 0, -1);
        // published vectors
        run_frame("key1", CMD_KEY, KEY1, 0, 0, 0, -1);
        run_frame("enc1", CMD_ENC, PT1, 0, 0, 1, -1);
        chk("enc1:ct", last_res, CT1);
        run_frame("dec1", CMD_DEC, CT1, 0, 0, 2, -1);
        chk("dec1:pt", last_res, PT1);

        // inter-byte timeout mid-payload: error, back to HUNT, no reply
        bq = {8'hA5, 8'h5A, CMD_KEY};
        repeat (5) bq.push_back(8'($urandom));
        got_q = {};
        e0 = n_err;
        drive(-1, 0);
        repeat (TO - 3) @(negedge sys_clk);
        chk("to:state_before", state, ST_PAYLOAD);
        chk("to:err_before", n_err - e0, 0);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge sys_clk);
            if (n_err - e0 == 1 && state == ST_HUNT) ok = 1'b1;
        end
        chk("to:fired", ok, 1);
        repeat (10) @(negedge sys_clk);
        chk("to:no_tx", got_q.size(), 0);
        chk("to:key_valid", key_valid, m_kv);
        // byte landing on the terminal count is accepted
        run_frame("tc_gap", CMD_KEY, KEY1, 0, 0, 0, 7);
        run_frame("after_to", CMD_ENC, PT1, 0, 0, 0, -1);

        // randomized frames
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 7))
                0, 1:    cb = CMD_KEY;
                2, 3, 7: cb = CMD_ENC;
                4, 5:    cb = CMD_DEC;
                default: begin
                    cb = 8'($urandom);
                    if (cb == CMD_KEY || cb == CMD_ENC || cb == CMD_DEC) cb = 8'h58;
                end
            endcase
            pl = {$urandom, $urandom, $urandom, $urandom};
            run_frame($sformatf("rnd%0d", it), cb, pl, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), -1);
        end

        // drop counter saturation during a long key expansion (key reload)
        kdone_delay = 400;
        run_frame("sat", CMD_KEY, KEY1, 0, 0, 260, -1);
        kdone_delay = 10;

        // reset in the middle of a 17-byte reply
        bq = {8'hA5, 8'h5A, CMD_ENC};
        for (int i = 0; i < BB; i++) bq.push_back(PT1[BW-1-8*i -: 8]);
        got_q = {};
        drive(-1, 0);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge sys_clk);
            if (got_q.size() >= 3) ok = 1'b1;
        end
        chk("rstsend:in_send", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstsend:tx_start", tx_start, 0);
        chk("rstsend:key_valid", key_valid, 0);
        chk("rstsend:state", state, ST_HUNT);
        chk("rstsend:drop_cnt", drop_cnt, 0);
        repeat (3) @(negedge sys_clk);
        rst_n  = 1'b1;
        m_kv   = 1'b0;
        m_drop = 0;
        repeat (2) @(negedge sys_clk);
        run_frame("post_rst_enc", CMD_ENC, PT1, 0, 0, 0, -1);
        run_frame("post_rst_key", CMD_KEY, KEY1, 1, 1, 1, -1);
        run_frame("post_rst_dec", CMD_DEC, CT1, 0, 0, 0, -1);
        chk("post_rst_dec:pt", last_res, PT1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
